// File: rtl/nor_chain_pulse_tester.sv
// nor_chain_pulse_tester
// Launches a train of pulses into a chain of NOR2_X1-style inverters and
// counts the edges that arrive at the chain output. A difference between the
// launched and observed edge counts shows that the chain filtered or
// cancelled pulses.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   start_i          single-cycle run request, honoured only while idle
//   pulse_width_i    high-phase length in cycles (0 behaves as 1)
//   gap_width_i      low-phase length in cycles (0 behaves as 1)
//   num_pulses_i     number of pulses in the train
//   chain_in_o       registered chain stimulus
//   chain_out_o      raw (unregistered) chain output
//   busy_o           high whenever the controller is not idle
//   done_o           one-cycle completion strobe
//   launched_edges_o edges driven into the chain in the current/last run
//   observed_edges_o edges seen at the synchronised chain output
//   mismatch_o       launched and observed counts differ, valid from done_o
module nor_chain_pulse_tester #(
  parameter int STAGES       = 26,
  parameter int PIN_MODE     = 0,
  parameter int WB           = 8,
  parameter int CB           = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [WB-1:0] pulse_width_i,
  input  logic [WB-1:0] gap_width_i,
  input  logic [CB-1:0] num_pulses_i,
  output logic          chain_in_o,
  output logic          chain_out_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CB:0]   launched_edges_o,
  output logic [CB:0]   observed_edges_o,
  output logic          mismatch_o
);

  // Phase counter must hold both the width fields and the drain length.
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int CW = (WB > DW) ? WB : DW;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_LOW   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CB-1:0] rem_q, rem_d;
  logic [WB-1:0] pw_q, pw_d;
  logic [WB-1:0] gw_q, gw_d;
  logic          chain_in_q, chain_in_d;
  logic [CB:0]   launched_q, launched_d;
  logic [CB:0]   observed_q, observed_d;
  logic          mismatch_q, mismatch_d;
  logic          busy_q, done_q;
  logic          s1_q, s2_q, s3_q;
  logic          count_en_s;
  logic [WB-1:0] pw_norm_s, gw_norm_s;

  // Saturating edge-counter increment.
  function automatic logic [CB:0] sat_inc(input logic [CB:0] v);
    if (v == {(CB+1){1'b1}}) begin
      return v;
    end else begin
      return v + (CB+1)'(1);
    end
  endfunction

  // Delay chain: each stage is a NOR2 with one pin tied low, i.e. an
  // inverter whose active pin is chosen by PIN_MODE.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic in_s, a1_s, a2_s, out_s;
    if (k == 0) begin : g_first
      assign in_s = chain_in_q;
    end else begin : g_next
      assign in_s = g_stage[k-1].out_s;
    end
    if ((PIN_MODE == 2) || ((PIN_MODE == 1) && ((k % 2) == 1))) begin : g_pin_a1
      assign a1_s = in_s;
      assign a2_s = 1'b0;
    end else begin : g_pin_a2
      assign a1_s = 1'b0;
      assign a2_s = in_s;
    end
    assign out_s = ~(a1_s | a2_s);
  end

  assign chain_out_o = g_stage[STAGES-1].out_s;

  assign pw_norm_s  = (pulse_width_i == '0) ? WB'(1) : pulse_width_i;
  assign gw_norm_s  = (gap_width_i == '0) ? WB'(1) : gap_width_i;
  assign count_en_s = (state_q == ST_HIGH) || (state_q == ST_LOW) || (state_q == ST_DRAIN);

  // Next-state, pulse sequencing and edge-count logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    pw_d       = pw_q;
    gw_d       = gw_q;
    chain_in_d = chain_in_q;
    launched_d = launched_q;
    observed_d = observed_q;
    mismatch_d = mismatch_q;

    // s2/s3 differ for exactly one cycle per edge seen at the chain output.
    if (count_en_s && (s2_q != s3_q)) begin
      observed_d = sat_inc(observed_q);
    end else begin
      observed_d = observed_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pw_d       = pw_norm_s;
          gw_d       = gw_norm_s;
          rem_d      = num_pulses_i;
          launched_d = '0;
          observed_d = '0;
          mismatch_d = 1'b0;
          if (num_pulses_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_HIGH;
            chain_in_d = 1'b1;
            launched_d = (CB+1)'(1);
            cnt_d      = CW'(pw_norm_s) - CW'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d    = ST_LOW;
          chain_in_d = 1'b0;
          launched_d = sat_inc(launched_q);
          cnt_d      = CW'(gw_q) - CW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          rem_d = rem_q - CB'(1);
          if (rem_q > CB'(1)) begin
            state_d    = ST_HIGH;
            chain_in_d = 1'b1;
            launched_d = sat_inc(launched_q);
            cnt_d      = CW'(pw_q) - CW'(1);
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = CW'(DRAIN_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          // Evaluated on the way into DONE so it is valid alongside done.
          state_d    = ST_DONE;
          mismatch_d = (launched_q != observed_d);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, synchroniser and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      pw_q       <= '0;
      gw_q       <= '0;
      chain_in_q <= 1'b0;
      launched_q <= '0;
      observed_q <= '0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      pw_q       <= pw_d;
      gw_q       <= gw_d;
      chain_in_q <= chain_in_d;
      launched_q <= launched_d;
      observed_q <= observed_d;
      mismatch_q <= mismatch_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      s1_q       <= chain_out_o;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  assign chain_in_o       = chain_in_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign launched_edges_o = launched_q;
  assign observed_edges_o = observed_q;
  assign mismatch_o       = mismatch_q;

endmodule

// File: tb/tb_nor_chain_pulse_tester.sv
// Bench for nor_chain_pulse_tester: four instances (26 stages with each pin
// mode, and 25 stages) share stimulus; expectations come from a run-level
// model of the pulse train (period, run length, edge counts).
module tb_nor_chain_pulse_tester;

  localparam int WB    = 8;
  localparam int CB    = 16;
  localparam int DRAIN = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WB-1:0] pw;
  logic [WB-1:0] gw;
  logic [CB-1:0] np;

  logic          ci [4];
  logic          co [4];
  logic          bz [4];
  logic          dn [4];
  logic          mm [4];
  logic [CB:0]   le [4];
  logic [CB:0]   oe [4];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  nor_chain_pulse_tester #(.STAGES(26), .PIN_MODE(0), .WB(WB), .CB(CB), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pulse_width_i(pw), .gap_width_i(gw),
    .num_pulses_i(np), .chain_in_o(ci[0]), .chain_out_o(co[0]), .busy_o(bz[0]), .done_o(dn[0]),
    .launched_edges_o(le[0]), .observed_edges_o(oe[0]), .mismatch_o(mm[0]));

  nor_chain_pulse_tester #(.STAGES(26), .PIN_MODE(1), .WB(WB), .CB(CB), .DRAIN_CYCLES(DRAIN)) dut_p1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pulse_width_i(pw), .gap_width_i(gw),
    .num_pulses_i(np), .chain_in_o(ci[1]), .chain_out_o(co[1]), .busy_o(bz[1]), .done_o(dn[1]),
    .launched_edges_o(le[1]), .observed_edges_o(oe[1]), .mismatch_o(mm[1]));

  nor_chain_pulse_tester #(.STAGES(26), .PIN_MODE(2), .WB(WB), .CB(CB), .DRAIN_CYCLES(DRAIN)) dut_p2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pulse_width_i(pw), .gap_width_i(gw),
    .num_pulses_i(np), .chain_in_o(ci[2]), .chain_out_o(co[2]), .busy_o(bz[2]), .done_o(dn[2]),
    .launched_edges_o(le[2]), .observed_edges_o(oe[2]), .mismatch_o(mm[2]));

  nor_chain_pulse_tester #(.STAGES(25), .PIN_MODE(0), .WB(WB), .CB(CB), .DRAIN_CYCLES(DRAIN)) dut_s25 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pulse_width_i(pw), .gap_width_i(gw),
    .num_pulses_i(np), .chain_in_o(ci[3]), .chain_out_o(co[3]), .busy_o(bz[3]), .done_o(dn[3]),
    .launched_edges_o(le[3]), .observed_edges_o(oe[3]), .mismatch_o(mm[3]));

  typedef struct {
    int p;
    int g;
    int n;
    int lat;
    int launched;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int norm(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  // Model: cycles from the accepting edge to done.
  function automatic int model_latency(input int p, input int g, input int n);
    if (n == 0) return 1;
    return n * (norm(p) + norm(g)) + DRAIN + 1;
  endfunction

  // Model: chain_in level k cycles after the accepting edge.
  function automatic bit model_chain_in(input int p, input int g, input int n, input int k);
    int per;
    per = norm(p) + norm(g);
    if (k > n * per) return 1'b0;
    return ((k - 1) % per) < norm(p);
  endfunction

  // One complete run; with fault set, the main instance's chain output is
  // held low across the second pulse so that pulse is swallowed.
  task automatic run(input int p, input int g, input int n, input int exp_lat,
                     input int exp_launched, input int exp_observed, input bit fault,
                     input string tag);
    int lat;
    int wave_err;
    int busy_err;
    int pol_err;
    int last;
    lat      = -1;
    wave_err = 0;
    busy_err = 0;
    pol_err  = 0;
    @(negedge clk);
    pw    = WB'(p);
    gw    = WB'(g);
    np    = CB'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (fault && k == 5) force dut.chain_out_o = 1'b0;
      if (fault && k == 10) release dut.chain_out_o;
      #0;
      for (int i = 0; i < 4; i++) begin
        if (ci[i] != model_chain_in(p, g, n, k)) wave_err++;
        if (bz[i] != 1'b1) busy_err++;
      end
      for (int i = (fault ? 1 : 0); i < 3; i++) begin
        if (co[i] != ci[i]) pol_err++;
      end
      if (co[3] != ~ci[3]) pol_err++;
      if (dn[0]) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_latency", tag), lat, exp_lat);
    chk($sformatf("%s_chain_in_wave_errs", tag), wave_err, 0);
    chk($sformatf("%s_busy_errs", tag), busy_err, 0);
    chk($sformatf("%s_polarity_errs", tag), pol_err, 0);
    if (lat >= 0) begin
      last = fault ? 0 : 3;
      for (int i = 0; i <= last; i++) begin
        chk($sformatf("%s_done_%0d", tag, i), dn[i], 1);
        chk($sformatf("%s_launched_%0d", tag, i), le[i], exp_launched);
        chk($sformatf("%s_observed_%0d", tag, i), oe[i], exp_observed);
        chk($sformatf("%s_mismatch_%0d", tag, i), mm[i], (exp_launched != exp_observed) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("%s_done_one_cycle", tag), dn[0], 0);
      chk($sformatf("%s_idle_busy", tag), bz[0], 0);
      @(posedge clk);
      #1;
      chk($sformatf("%s_hold_launched", tag), le[0], exp_launched);
      chk($sformatf("%s_hold_observed", tag), oe[0], exp_observed);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int g;
    int n;

    vecs[0] = '{p: 3, g: 2, n: 4, lat: 29, launched: 8};
    vecs[1] = '{p: 0, g: 0, n: 2, lat: 13, launched: 4};
    vecs[2] = '{p: 0, g: 0, n: 0, lat: 1,  launched: 0};
    vecs[3] = '{p: 1, g: 1, n: 1, lat: 11, launched: 2};
    vecs[4] = '{p: 5, g: 3, n: 2, lat: 25, launched: 4};
    vecs[5] = '{p: 2, g: 7, n: 3, lat: 36, launched: 6};
    vecs[6] = '{p: 1, g: 4, n: 0, lat: 1,  launched: 0};

    rst   = 1'b1;
    start = 1'b0;
    pw    = '0;
    gw    = '0;
    np    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_chain_in", ci[0], 0);
    chk("reset_busy", bz[0], 0);
    chk("reset_done", dn[0], 0);
    chk("reset_launched", le[0], 0);
    chk("reset_observed", oe[0], 0);
    chk("reset_mismatch", mm[0], 0);
    chk("reset_chain_out_even", co[0], 0);
    chk("reset_chain_out_odd", co[3], 1);

    for (int v = 0; v < 7; v++) begin
      run(vecs[v].p, vecs[v].g, vecs[v].n, vecs[v].lat, vecs[v].launched,
          vecs[v].launched, 1'b0, $sformatf("vec%0d", v));
    end

    // Second start mid-run is ignored; reset during HIGH of pulse 2 aborts.
    @(negedge clk);
    pw    = 8'd3;
    gw    = 8'd2;
    np    = 16'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    pw    = 8'd1;
    np    = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("midrun_busy_k3", bz[0], 1);
    chk("midrun_chain_in_k3", ci[0], 1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_chain_in_k7", ci[0], 1);
    chk("midrun_launched_k7", le[0], 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", bz[0], 0);
    chk("abort_chain_in", ci[0], 0);
    chk("abort_launched", le[0], 0);
    chk("abort_observed", oe[0], 0);
    chk("abort_done", dn[0], 0);
    chk("abort_mismatch", mm[0], 0);
    repeat (4) @(posedge clk);
    run(3, 2, 4, 29, 8, 8, 1'b0, "after_abort");

    // Swallowed pulse: one pulse of three never reaches the output.
    run(3, 2, 3, 24, 6, 4, 1'b1, "swallow");
    repeat (4) @(posedge clk);
    run(2, 1, 2, 15, 4, 4, 1'b0, "clean_after_swallow");

    // Randomised runs against the model.
    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(0, 6));
      g = int'($urandom_range(0, 6));
      n = int'($urandom_range(0, 5));
      run(p, g, n, model_latency(p, g, n), 2 * n, 2 * n, 1'b0, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/nor_chain_pulse_tester.md
# nor_chain_pulse_tester

Parametrised delay-chain test block: a synchronous pulse-train launcher drives a NOR2_X1 inverter chain of configurable depth and input-pin assignment. The block samples the chain output and counts the transitions that arrive, so that pulse filtering or cancellation in the chain shows up as a launched/observed edge-count mismatch. It sits between the evaluation testbench/controller and the gate-level chain used for delay-model evaluation.

## Interface
- STAGES, 26: number of NOR2_X1 stages in the chain; must be ≥1.
- PIN_MODE, 0: chain-signal pin per stage; the other pin ties to constant 0.
  - 0: all stages use A2.
  - 1: even-indexed stages use A2, odd-indexed stages use A1.
  - 2: all stages use A1.
- WB, 8: width of the pulse/gap length fields.
- CB, 16: width of the pulse-count field.
- DRAIN_CYCLES, 8: settle cycles after the last launched edge; must be ≥4.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- pulse_width  in  WB  high-phase length in cycles; 0 is treated as 1. Latched at start.
- gap_width  in  WB  low-phase length in cycles; 0 is treated as 1. Latched at start.
- num_pulses  in  CB  number of pulses in the train. Latched at start.
- chain_in  out  1  registered chain stimulus; observable for probing.
- chain_out  out  1  raw chain output, unregistered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion strobe.
- launched_edges  out  CB+1  edges driven into the chain during the current/last run.
- observed_edges  out  CB+1  edges detected at the synchronised chain output.
- mismatch  out  1  launched_edges ≠ observed_edges, valid from done.

## Operation
- Chain: stage 0 input is chain_in; stage k input is the output of stage k−1; chain_out is the output of the last stage. Pin selection follows PIN_MODE. Chain polarity equals chain_in when STAGES is even and its inverse when STAGES is odd.
- Edge detection:
  - chain_out passes through a 2-FF synchroniser (s1, s2), then a 1-FF history register s3.
  - An edge is counted when s2≠s3 while counting is enabled.
- FSM states: IDLE, HIGH, LOW, DRAIN, DONE.
  - IDLE: on start, latch the inputs and clear both edge counters and mismatch.
    - If num_pulses=0, go to DONE.
    - Otherwise go to HIGH and set chain_in=1.
  - HIGH: hold chain_in=1 for max(pulse_width,1) cycles, then clear chain_in to 0 and go to LOW.
  - LOW: hold chain_in=0 for max(gap_width,1) cycles. Decrement the remaining-pulse count.
    - If pulses remain, go to HIGH.
    - Otherwise go to DRAIN. The gap after the last pulse is still inserted.
  - DRAIN: wait DRAIN_CYCLES cycles, then go to DONE.
  - DONE: assert done for one cycle, update mismatch, go to IDLE.
- launched_edges increments by 1 on every chain_in toggle, so a completed run yields 2·num_pulses.
- Edge counting is enabled from the cycle after start is accepted through DRAIN. The history register s3 is loaded at start without counting.
- Counters saturate at all-ones and do not wrap.
- launched_edges, observed_edges and mismatch hold their values in IDLE until the next accepted start.
- start while busy is ignored and leaves no side effects.
- Reset, including mid-run: FSM to IDLE, chain_in=0, both counters=0, s1/s2/s3=0, busy=0, done=0, mismatch=0. In-flight chain edges are discarded.

## Timing
- start accepted in cycle T: chain_in=1 at T+1 and busy=1 at T+1.
- With pulse_width=P and gap_width=G (each ≥1):
  - chain_in is high for P cycles and low for at least G cycles per pulse.
  - Pulse period is P+G cycles.
- Observation latency: a chain_out change settled before clock edge n is counted at edge n+2.
- Run length from start to done: N·(P+G) + DRAIN_CYCLES + 1 cycles.
- num_pulses=0: done asserted at T+1 with both counts 0 and mismatch=0.
- done and mismatch are registered. mismatch is valid in the same cycle as done.
- With zero-delay gates, every edge reaches the output within the same cycle, so observed equals launched. Back-annotated runs with sub-cycle pulses may legitimately show observed < launched.

## Test plan
- Reset, then hold idle: all outputs 0, chain_out=0 for even STAGES and 1 for odd STAGES, busy=0.
- STAGES=26, PIN_MODE=0, P=3, G=2, N=4 → chain_in shows 4 pulses of 3 cycles high. Done occurs 29 cycles after start. launched_edges=8, observed_edges=8, mismatch=0.
- Same run for PIN_MODE=1, PIN_MODE=2 and STAGES=25 → identical counts. For STAGES=25, chain_out is the inverse of chain_in.
- P=0, G=0, N=2 → widths treated as 1, launched_edges=4, done 13 cycles after start. N=0 → done at T+1 with counts 0.
- start pulsed again mid-run, and rst asserted during HIGH of pulse 2 → the second start is ignored. Reset yields IDLE next cycle with chain_in=0 and counters 0. A fresh run then completes normally.
- Force the chain output (bench override) to swallow one pulse, N=3 → launched_edges=6, observed_edges=4, mismatch=1 at done.
